// File: rtl/posit_result_checker.sv
// Result-side scoreboard for a pipelined posit adder: delays golden values by LATENCY and compares.
// Optional first-failure capture ports are enabled by defining POSIT_CHK_FIRST_ERR_EN.
module posit_result_checker #(
  parameter int N       = 32,
  parameter int ES      = 3,
  parameter int LATENCY = 8,
  parameter int TOL     = 0,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     exp_in,
  input  logic [N-1:0]     dut_result,
  input  logic             dut_done,
  input  logic             dut_inf,
  input  logic             dut_zero,
  output logic             chk_valid,
  output logic             mismatch,
  output logic [N-1:0]     diff,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic [N-1:0]     max_diff,
  output logic             busy,
  output logic             finished
`ifdef POSIT_CHK_FIRST_ERR_EN
  ,
  output logic [N-1:0]     first_err_exp,
  output logic [N-1:0]     first_err_res,
  output logic [CNT_W-1:0] first_err_idx
`endif
);

  // state | meaning
  // IDLE  | after reset, nothing issued yet
  // RUN   | operands being issued
  // DRAIN | issue paused, waiting LATENCY cycles for in-flight results
  // DONE  | run complete, statistics held

  // ES only documents the adder configuration; reject nonsense settings at elaboration.
  if (LATENCY < 1 || ES < 0 || ES >= N) begin : g_bad_params
    $error("posit_result_checker: LATENCY must be >= 1 and ES in [0, N)");
  end

  localparam int             DRW    = $clog2(LATENCY + 1);
  localparam logic [N-1:0]   NAR    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   TOL_V  = N'(TOL);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [DRW-1:0]   drain_cnt, drain_nxt;
  logic             run_clear;

  logic [LATENCY-1:0] pipe_vld;
  logic [N-1:0]       pipe_exp [LATENCY];

  logic               tail_vld;
  logic [N-1:0]       tail_exp;
  logic [N-1:0]       abs_diff;
  logic               fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_exp[i] <= '0;
    end else begin
      pipe_vld[0] <= start;
      pipe_exp[0] <= exp_in;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
      end
    end
  end

  assign tail_vld = pipe_vld[LATENCY-1];
  assign tail_exp = pipe_exp[LATENCY-1];

  always_comb begin
    abs_diff = (tail_exp > dut_result) ? (tail_exp - dut_result) : (dut_result - tail_exp);
    fail     = tail_vld & (!dut_done
                           || (tail_exp == NAR && !dut_inf)
                           || (tail_exp == '0 && !dut_zero)
                           || (abs_diff > TOL_V));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    run_clear = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          run_clear = 1'b1;
        end
      end
      RUN: begin
        if (!start) begin
          state_nxt = DRAIN;
          drain_nxt = DRW'(LATENCY);
        end
      end
      DRAIN: begin
        if (start) begin
          state_nxt = RUN;
        end else begin
          drain_nxt = drain_cnt - DRW'(1);
          if (drain_cnt == DRW'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          run_clear = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == RUN) || (state == DRAIN);
  assign finished = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_valid <= 1'b0;
      mismatch  <= 1'b0;
      diff      <= '0;
      chk_count <= '0;
      err_count <= '0;
      max_diff  <= '0;
    end else begin
      chk_valid <= tail_vld;
      mismatch  <= fail;
      diff      <= tail_vld ? abs_diff : '0;
      if (run_clear) begin
        chk_count <= '0;
        err_count <= '0;
        max_diff  <= '0;
      end else if (tail_vld) begin
        if (chk_count != '1) chk_count <= chk_count + CNT_W'(1);
        if (fail && err_count != '1) err_count <= err_count + CNT_W'(1);
        if (abs_diff > max_diff) max_diff <= abs_diff;
      end
    end
  end

`ifdef POSIT_CHK_FIRST_ERR_EN
  // err_count is zero exactly until the first fail of the run, so it doubles as the capture flag.
  always_ff @(posedge clk) begin
    if (rst || run_clear) begin
      first_err_exp <= '0;
      first_err_res <= '0;
      first_err_idx <= '0;
    end else if (fail && err_count == '0) begin
      first_err_exp <= tail_exp;
      first_err_res <= dut_result;
      first_err_idx <= chk_count;
    end
  end
`endif

endmodule

// File: tb/tb_posit_result_checker.sv
// Directed self-checking bench for posit_result_checker (LATENCY=8, TOL=0).
module tb_posit_result_checker;
  localparam int N     = 32;
  localparam int LAT   = 8;
  localparam int CNT_W = 32;
  localparam int SZ    = 64;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [N-1:0]     exp_in, dut_result;
  logic             dut_done, dut_inf, dut_zero;
  logic             chk_valid, mismatch, busy, finished;
  logic [N-1:0]     diff, max_diff;
  logic [CNT_W-1:0] chk_count, err_count;
`ifdef POSIT_CHK_FIRST_ERR_EN
  logic [N-1:0]     first_err_exp, first_err_res;
  logic [CNT_W-1:0] first_err_idx;
`endif

  int errors = 0;
  int checks = 0;

  // Stimulus schedule indexed by cycle, and outputs observed after each edge (index = cycle+1).
  logic         s_start [SZ];
  logic [N-1:0] s_exp   [SZ];
  logic [N-1:0] r_res   [SZ];
  logic         r_done  [SZ];
  logic         r_inf   [SZ];
  logic         r_zero  [SZ];
  logic         o_vld   [SZ];
  logic         o_mis   [SZ];
  logic [N-1:0] o_diff  [SZ];
  logic         o_busy  [SZ];

  posit_result_checker #(.N(N), .ES(3), .LATENCY(LAT), .TOL(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_in(exp_in),
    .dut_result(dut_result), .dut_done(dut_done), .dut_inf(dut_inf), .dut_zero(dut_zero),
    .chk_valid(chk_valid), .mismatch(mismatch), .diff(diff),
    .chk_count(chk_count), .err_count(err_count), .max_diff(max_diff),
    .busy(busy), .finished(finished)
`ifdef POSIT_CHK_FIRST_ERR_EN
    ,
    .first_err_exp(first_err_exp), .first_err_res(first_err_res), .first_err_idx(first_err_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sched;
    for (int i = 0; i < SZ; i++) begin
      s_start[i] = 1'b0; s_exp[i] = '0;
      r_res[i] = '0; r_done[i] = 1'b0; r_inf[i] = 1'b0; r_zero[i] = 1'b0;
      o_vld[i] = 1'b0; o_mis[i] = 1'b0; o_diff[i] = '0; o_busy[i] = 1'b0;
    end
  endtask

  // Ideal adder returns its answer LAT cycles after issue.
  task automatic issue(input int t, input logic [N-1:0] e, input logic [N-1:0] res,
                       input logic done, input logic inf, input logic zero);
    s_start[t] = 1'b1;
    s_exp[t] = e;
    r_res[t+LAT] = res;
    r_done[t+LAT] = done;
    r_inf[t+LAT] = inf;
    r_zero[t+LAT] = zero;
  endtask

  task automatic run_sched(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      start = s_start[c]; exp_in = s_exp[c];
      dut_result = r_res[c]; dut_done = r_done[c]; dut_inf = r_inf[c]; dut_zero = r_zero[c];
      tick;
      o_vld[c+1] = chk_valid; o_mis[c+1] = mismatch; o_diff[c+1] = diff; o_busy[c+1] = busy;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; exp_in = '0;
    dut_result = '0; dut_done = 1'b0; dut_inf = 1'b0; dut_zero = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick; tick;
    checks++; if (chk_valid !== 1'b0) begin errors++; $display("FAIL reset chk_valid: got %b want 0", chk_valid); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset mismatch: got %b want 0", mismatch); end
    checks++; if (diff !== '0) begin errors++; $display("FAIL reset diff: got %h want 0", diff); end
    checks++; if (chk_count !== '0) begin errors++; $display("FAIL reset chk_count: got %0d want 0", chk_count); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL reset err_count: got %0d want 0", err_count); end
    checks++; if (max_diff !== '0) begin errors++; $display("FAIL reset max_diff: got %h want 0", max_diff); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL reset finished: got %b want 0", finished); end
  endtask

  task automatic test_fixed_timing;
    logic want;
    clear_sched;
    for (int i = 0; i < 5; i++) issue(i, 32'h40000000 + N'(i), 32'h40000000 + N'(i), 1'b1, 1'b0, 1'b0);
    run_sched(26);
    for (int c = 1; c <= 26; c++) begin
      want = (c >= 9 && c <= 13);
      checks++;
      if (o_vld[c] !== want || o_mis[c] !== 1'b0) begin
        errors++;
        $display("FAIL fixed cycle %0d chk_valid/mismatch: got %b/%b want %b/0", c, o_vld[c], o_mis[c], want);
      end
    end
    checks++; if (o_busy[1] !== 1'b1 || o_busy[13] !== 1'b1) begin errors++; $display("FAIL fixed busy: got %b,%b want 1,1", o_busy[1], o_busy[13]); end
    checks++; if (chk_count !== 5) begin errors++; $display("FAIL fixed chk_count: got %0d want 5", chk_count); end
    checks++; if (err_count !== 0) begin errors++; $display("FAIL fixed err_count: got %0d want 0", err_count); end
    checks++; if (max_diff !== '0) begin errors++; $display("FAIL fixed max_diff: got %h want 0", max_diff); end
    checks++; if (finished !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fixed finished/busy: got %b/%b want 1/0", finished, busy); end
  endtask

  task automatic test_off_by_one;
    logic want;
    clear_sched;
    for (int i = 0; i < 5; i++)
      issue(i, 32'h40000000 + N'(i), (i == 2) ? 32'h40000003 : 32'h40000000 + N'(i), 1'b1, 1'b0, 1'b0);
    run_sched(26);
    for (int c = 9; c <= 13; c++) begin
      want = (c == 11);
      checks++;
      if (o_mis[c] !== want) begin errors++; $display("FAIL offby1 mismatch cycle %0d: got %b want %b", c, o_mis[c], want); end
    end
    checks++; if (o_diff[11] !== 32'd1) begin errors++; $display("FAIL offby1 diff: got %h want 1", o_diff[11]); end
    checks++; if (chk_count !== 5) begin errors++; $display("FAIL offby1 chk_count: got %0d want 5", chk_count); end
    checks++; if (err_count !== 1) begin errors++; $display("FAIL offby1 err_count: got %0d want 1", err_count); end
    checks++; if (max_diff !== 32'd1) begin errors++; $display("FAIL offby1 max_diff: got %h want 1", max_diff); end
`ifdef POSIT_CHK_FIRST_ERR_EN
    checks++; if (first_err_idx !== 2) begin errors++; $display("FAIL offby1 first_err_idx: got %0d want 2", first_err_idx); end
    checks++; if (first_err_exp !== 32'h40000002 || first_err_res !== 32'h40000003) begin
      errors++; $display("FAIL offby1 first_err exp/res: got %h/%h want 40000002/40000003", first_err_exp, first_err_res);
    end
`endif
  endtask

  task automatic test_special;
    clear_sched;
    issue(0, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0);
    issue(1, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1);
    issue(2, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0);
    run_sched(26);
    checks++; if (o_mis[9] !== 1'b1 || o_diff[9] !== '0) begin errors++; $display("FAIL nar_no_inf mismatch/diff: got %b/%h want 1/0", o_mis[9], o_diff[9]); end
    checks++; if (o_mis[10] !== 1'b0) begin errors++; $display("FAIL zero_flag mismatch: got %b want 0", o_mis[10]); end
    checks++; if (o_mis[11] !== 1'b0) begin errors++; $display("FAIL nar_inf mismatch: got %b want 0", o_mis[11]); end
    checks++; if (err_count !== 1 || chk_count !== 3) begin errors++; $display("FAIL special err/chk count: got %0d/%0d want 1/3", err_count, chk_count); end
`ifdef POSIT_CHK_FIRST_ERR_EN
    checks++; if (first_err_idx !== 0 || first_err_exp !== 32'h80000000) begin
      errors++; $display("FAIL special first_err idx/exp: got %0d/%h want 0/80000000", first_err_idx, first_err_exp);
    end
`endif
  endtask

  task automatic test_bubble;
    clear_sched;
    issue(0, 32'h3c000000, 32'h3c000000, 1'b1, 1'b0, 1'b0);
    issue(2, 32'h3c000001, 32'h3c000001, 1'b1, 1'b0, 1'b0);
    r_done[1+LAT] = 1'b0;
    run_sched(26);
    checks++; if (o_vld[9] !== 1'b1 || o_vld[10] !== 1'b0 || o_vld[11] !== 1'b1) begin
      errors++; $display("FAIL bubble chk_valid 9/10/11: got %b%b%b want 101", o_vld[9], o_vld[10], o_vld[11]);
    end
    checks++; if (chk_count !== 2 || err_count !== 0) begin errors++; $display("FAIL bubble chk/err count: got %0d/%0d want 2/0", chk_count, err_count); end

    clear_sched;
    issue(0, 32'h3c000000, 32'h3c000000, 1'b0, 1'b0, 1'b0);
    run_sched(22);
    checks++; if (o_vld[9] !== 1'b1 || o_mis[9] !== 1'b1) begin errors++; $display("FAIL not_done valid/mismatch: got %b/%b want 1/1", o_vld[9], o_mis[9]); end
    checks++; if (chk_count !== 1 || err_count !== 1) begin errors++; $display("FAIL not_done chk/err count: got %0d/%0d want 1/1", chk_count, err_count); end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    clear_sched;
    for (int i = 0; i < 4; i++) issue(i, 32'h41000000 + N'(i), 32'h41000000 + N'(i), 1'b1, 1'b0, 1'b0);
    run_sched(5);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 16; c++) begin
      dut_done = 1'b1; dut_result = 32'h41000000;
      tick;
      if (chk_valid === 1'b1) seen++;
    end
    dut_done = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst chk_valid pulses: got %0d want 0", seen); end
    checks++; if (busy !== 1'b0 || finished !== 1'b0) begin errors++; $display("FAIL midrst busy/finished: got %b/%b want 0/0", busy, finished); end
    checks++; if (chk_count !== 0 || err_count !== 0) begin errors++; $display("FAIL midrst counts: got %0d/%0d want 0/0", chk_count, err_count); end

    clear_sched;
    issue(0, 32'h42000000, 32'h42000000, 1'b1, 1'b0, 1'b0);
    issue(1, 32'h42000001, 32'h42000001, 1'b1, 1'b0, 1'b0);
    run_sched(24);
    checks++; if (chk_count !== 2 || err_count !== 0) begin errors++; $display("FAIL rerun counts: got %0d/%0d want 2/0", chk_count, err_count); end
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL rerun finished: got %b want 1", finished); end
  endtask

  initial begin
    test_reset;
    test_fixed_timing;
    test_off_by_one;
    test_special;
    test_bubble;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
